// File: rtl/sync_updown_counter.sv
// Modulo-MOD up/down counter with enable, parallel load, wrap/saturate mode,
// terminal-count output and registered wrap / out-of-range-load pulses.
module sync_updown_counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MOD     = 16,
    parameter longint unsigned RST_VAL = MOD - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    // Range ends are explicit constants so MOD < 2^WIDTH never leans on natural overflow.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sync_updown_counter: WIDTH must be in 1..32");
    end
    if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("sync_updown_counter: MOD must be in 2..2^WIDTH");
    end
    if (RST_VAL >= MOD) begin : g_bad_rst
        $error("sync_updown_counter: RST_VAL must be below MOD");
    end

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             err_next;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (load) begin
            if (din > MAX_Q) begin
                q_next   = MAX_Q;
                err_next = 1'b1;
            end else begin
                q_next = din;
            end
        end else if (en) begin
            if (up_dn) begin
                if (q != MAX_Q) begin
                    q_next = q + WIDTH'(1);
                end else if (!sat) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (q != '0) begin
                    q_next = q - WIDTH'(1);
                end else if (!sat) begin
                    q_next    = MAX_Q;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RST_Q;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
            err  <= err_next;
        end
    end

    assign tc = up_dn ? (q == MAX_Q) : (q == '0);

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench: a MOD=10 instance for the main behaviour and a MOD=8
// instance for the binary-equivalent (legacy 3-bit down counter) sequence.
module tb_sync_updown_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, modulus 10
    logic       a_rst, a_en, a_up_dn, a_sat, a_load;
    logic [3:0] a_din, a_q;
    logic       a_tc, a_wrap, a_err;

    // Binary-equivalent instance, modulus 8
    logic       b_rst, b_en, b_up_dn, b_sat, b_load;
    logic [2:0] b_din, b_q;
    logic       b_tc, b_wrap, b_err;

    int checks = 0;
    int errors = 0;

    sync_updown_counter #(.WIDTH(4), .MOD(10), .RST_VAL(9)) u_dut (
        .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up_dn), .sat(a_sat),
        .load(a_load), .din(a_din), .q(a_q), .tc(a_tc), .wrap(a_wrap), .err(a_err)
    );

    sync_updown_counter #(.WIDTH(3), .MOD(8), .RST_VAL(7)) u_bin (
        .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up_dn), .sat(b_sat),
        .load(b_load), .din(b_din), .q(b_q), .tc(b_tc), .wrap(b_wrap), .err(b_err)
    );

    // Hand-computed sequences after each counting edge.
    int dn_q   [11] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
    int dn_wrap[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int up_q   [4]  = '{8, 9, 0, 1};
    int up_wrap[4]  = '{0, 0, 1, 0};
    int up_tc  [4]  = '{0, 1, 0, 0};
    int bn_q   [10] = '{6, 5, 4, 3, 2, 1, 0, 7, 6, 5};
    int bn_wrap[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int q_e, input int tc_e,
                           input int wrap_e, input int err_e);
        check({tag, "_q"},    32'(a_q),    q_e);
        check({tag, "_tc"},   32'(a_tc),   tc_e);
        check({tag, "_wrap"}, 32'(a_wrap), wrap_e);
        check({tag, "_err"},  32'(a_err),  err_e);
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b1; a_up_dn = 1'b0; a_sat = 1'b0; a_load = 1'b0; a_din = 4'd0;
        b_rst = 1'b1; b_en = 1'b0; b_up_dn = 1'b0; b_sat = 1'b0; b_load = 1'b0; b_din = 3'd0;

        // Reset state
        step();
        check_a("rst", 9, 0, 0, 0);
        a_up_dn = 1'b1; #1;
        check("rst_tc_up", 32'(a_tc), 1);

        // Down count, wrap mode
        a_rst = 1'b0; a_en = 1'b1; a_up_dn = 1'b0; a_sat = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step();
            check_a($sformatf("dn%0d", i), dn_q[i], (dn_q[i] == 0) ? 1 : 0, dn_wrap[i], 0);
        end

        // Load 7 with en=1: load wins, then count up and wrap
        a_load = 1'b1; a_din = 4'd7;
        step();
        check_a("ld7", 7, 0, 0, 0);
        a_load = 1'b0; a_up_dn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_a($sformatf("up%0d", i), up_q[i], up_tc[i], up_wrap[i], 0);
        end

        // Saturate up from 8
        a_sat = 1'b1; a_load = 1'b1; a_din = 4'd8;
        step();
        check("sat_ld8_q", 32'(a_q), 8);
        a_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_a($sformatf("satup%0d", i), 9, 1, 0, 0);
        end

        // Saturate down from 1
        a_load = 1'b1; a_din = 4'd1; a_up_dn = 1'b0;
        step();
        check("sat_ld1_q", 32'(a_q), 1);
        a_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_a($sformatf("satdn%0d", i), 0, 1, 0, 0);
        end

        // Out-of-range load with en=1, then idle clears err
        a_sat = 1'b0; a_up_dn = 1'b1; a_load = 1'b1; a_din = 4'd12;
        step();
        check_a("ld12", 9, 1, 0, 1);
        a_load = 1'b0; a_en = 1'b0;
        step();
        check_a("idle", 9, 1, 0, 0);

        // In-range load with en=1: no count this cycle
        a_en = 1'b1; a_load = 1'b1; a_din = 4'd3;
        step();
        check_a("ld3", 3, 0, 0, 0);

        // Boundary loads: 9 is legal, 10 and 15 are not; back-to-back err stays high
        a_din = 4'd9;
        step();
        check_a("ld9", 9, 1, 0, 0);
        a_din = 4'd10;
        step();
        check_a("ld10", 9, 1, 0, 1);
        a_din = 4'd15;
        step();
        check_a("ld15", 9, 1, 0, 1);

        // Count up to 5, then reset together with load
        a_din = 4'd4;
        step();
        a_load = 1'b0;
        step();
        check("pre_rst_q", 32'(a_q), 5);
        a_rst = 1'b1; a_load = 1'b1; a_din = 4'd2;
        step();
        check_a("rst_ld", 9, 1, 0, 0);
        a_rst = 1'b0; a_load = 1'b0;
        step();
        check_a("resume", 0, 0, 1, 0);

        // Direction change at q=0: down wrap to 9
        a_up_dn = 1'b0;
        #1;
        check("dir_tc", 32'(a_tc), 1);
        step();
        check_a("dnwrap", 9, 0, 1, 0);

        // Reset clears a pending err pulse
        a_load = 1'b1; a_din = 4'd13;
        step();
        check("err_set", 32'(a_err), 1);
        a_load = 1'b0; a_rst = 1'b1;
        step();
        check_a("rst_err", 9, 0, 0, 0);
        a_rst = 1'b0; a_en = 1'b0;

        // Binary-equivalent configuration: legacy 3-bit down counter
        check("bin_rst_q", 32'(b_q), 7);
        b_rst = 1'b0; b_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("bin%0d_q", i), 32'(b_q), bn_q[i]);
            check($sformatf("bin%0d_wrap", i), 32'(b_wrap), bn_wrap[i]);
        end

        // Up wrap at full binary range: 5 -> 6 -> 7 -> 0
        b_up_dn = 1'b1;
        step();
        check("binup0_q", 32'(b_q), 6);
        step();
        check("binup1_q", 32'(b_q), 7);
        check("binup1_tc", 32'(b_tc), 1);
        step();
        check("binup2_q", 32'(b_q), 0);
        check("binup2_wrap", 32'(b_wrap), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
